multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing the multicycle RV32 datapath: fetch, decode, execute, memory, writeback.
//  Reads instruction fields/Zero from datapath; drives every datapath enable/mux select plus MemWrite_o.
//  Sits beside the datapath in the CPU top; one instruction in flight, no pipelining.
// PARAMETERS
//  XLEN  32  datapath width (only the width of nothing here; kept for top-level uniformity)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high
//  opcode       in   7  IR[6:0] from datapath
//  funct3       in   3  IR[14:12] from datapath
//  Zero         in   1  ALU zero flag (combinational, current srcA/srcB)
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  held 0 (branch resolved inside this block)
//  PCSource     out  2  00 PC+4, 01 ALUOut, 10 ALUResult&~1
//  IorD         out  1  0 PC, 1 ALUOut on address bus
//  IRWrite      out  1  load IR from ProgIn_i
//  MemWrite_o   out  1  data memory write strobe
//  MemtoReg     out  2  00 ALUOut, 01 DataIn_i, 10 PC+4
//  RegWrite     out  1  register file write
//  ALUOp        out  2  00 add, 01 sub (branch), 10 R funct, 11 I funct
//  ALUSrcA      out  2  00 PC, 01 A
//  ALUSrcB      out  2  00 B, 01 const 4, 10 Imm
//  LatchAB      out  1  capture rs1/rs2 into A/B
//  ALUOutEn     out  1  capture ALUResult into ALUOut
//  ImmSrc       out  3  000 I, 001 S, 010 B, 011 U, 100 J (decoded from opcode every state)
//  illegal_o    out  1  sticky: unsupported opcode seen
//  retire_o     out  1  1-cycle pulse in last state of each instruction
//  mem_ready_i  in   1  (only with MC_MEM_HANDSHAKE_EN) data memory ready
// BEHAVIOUR
//  Reset: state=FETCH; all outputs 0 (FETCH decodes to all-zero); illegal_o=0. Outputs are pure f(state,opcode,funct3,Zero).
//  FETCH: IorD=0, ROM addressed by PC (sync ROM) -> IRLOAD.  IRLOAD: IRWrite=1 -> DECODE.
//  DECODE: LatchAB=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ALUOutEn=1 (ALUOut<=PC+Imm). Dispatch on opcode:
//   0110011 R -> EXEC_R; 0010011 I -> EXEC_I; 0000011/0100011 LW/SW -> MEM_ADDR; 1100011 -> BRANCH;
//   1101111 -> JAL; 1100111 -> JALR; 0010111 AUIPC -> WB_ALU; other -> ILLEGAL.
//  EXEC_R: SrcA=01,SrcB=00,ALUOp=10,ALUOutEn -> WB_ALU.  EXEC_I: SrcA=01,SrcB=10,ALUOp=11,ALUOutEn -> WB_ALU.
//  WB_ALU: RegWrite, MemtoReg=00, PCWrite, PCSource=00, retire -> FETCH.
//  MEM_ADDR: SrcA=01,SrcB=10,ALUOp=00,ALUOutEn -> MEM_RD (load) / MEM_WR (store).
//  MEM_RD: IorD=1 -> WB_MEM.  WB_MEM: RegWrite, MemtoReg=01, PCWrite, PCSource=00, retire -> FETCH.
//  MEM_WR: IorD=1, MemWrite_o=1, PCWrite, PCSource=00, retire -> FETCH.
//  BRANCH: SrcA=01,SrcB=00,ALUOp=01; taken = (f3==000&Zero)|(f3==001&!Zero); other funct3 = not taken.
//   PCWrite=1, PCSource = taken?01:00, retire -> FETCH.
//  JAL: RegWrite, MemtoReg=10 (old PC+4), PCWrite, PCSource=01, retire -> FETCH.
//  JALR: SrcA=01,SrcB=10,ALUOp=00, RegWrite, MemtoReg=10, PCWrite, PCSource=10, retire -> FETCH.
//  rd write and PC update share one edge; RF sees PC+4 of old PC. rd=x0 discard is the RF's job.
//  ILLEGAL: all outputs 0, illegal_o=1, stays until reset. Reset mid-instruction: immediate return to FETCH, no writes.
//  CPI: R/I/AUIPC 4-5, LW 6, SW 5, branch/JAL/JALR 4.
// CONFIGURATION
//  MC_MEM_HANDSHAKE_EN defined: mem_ready_i exists; MEM_RD and MEM_WR hold (outputs stable, MemWrite_o held)
//   until mem_ready_i=1, then advance; PC update/retire only on the ready cycle.
//  Undefined: no port; MEM_RD/MEM_WR last exactly 1 cycle.
// STRUCTURE
//  mc_ctrl_pkg: state_t enum, OPC_* opcode constants, ALUOP_*/IMM_*/PCSRC_*/SRCA_*/SRCB_*/WB_* encodings.
//  Sub-module mc_imm_decode: opcode -> ImmSrc (combinational); FSM + output decode stay in this file.
// TESTING
//  add x3,x1,x2 (x1=5,x2=7) -> 5 cycles FETCH..WB_ALU, RegWrite with ALUOut=12, PC 0->4, one retire_o.
//  lw x5,8(x0) then sw x5,12(x0) -> MEM_RD IorD=1; WB_MEM MemtoReg=01; MEM_WR MemWrite_o=1 addr 12, exactly one strobe.
//  beq x1,x1,-8 at PC=16 -> PCSource=01, PC=8; bne x1,x1 -> PCSource=00, PC=20.
//  jal x1,+32 at PC=4 -> x1=8, PC=36 same edge; jalr x0,3(x1) with x1=8 -> PC=10 (bit0 cleared).
//  opcode 0110111 -> ILLEGAL, illegal_o=1 held, outputs 0; reset -> FETCH, illegal_o=0.
//  reset asserted in MEM_WR -> MemWrite_o drops asynchronously; MC_MEM_HANDSHAKE_EN: ready low 3 cycles -> MEM_WR held 4 cycles.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states,
// opcode constants and the datapath mux/ALU select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_IRLOAD   = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_RFN = 2'b10;
    localparam logic [1:0] ALUOP_IFN = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_ALU  = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_A  = 2'b01;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // beq/bne only; every other funct3 falls through as not taken
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == 3'b000) && zero) || ((f3 == 3'b001) && !zero);
    endfunction

endpackage

// File: rtl/multicycle_control_imm_decode.sv
// Immediate format select from the opcode; purely combinational.
module mc_imm_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_imm_src
);

    // Opcode to immediate format; anything unrecognised defaults to I-type
    always_comb begin
        o_imm_src = IMM_I;
        case (i_opcode)
            OPC_STORE:          o_imm_src = IMM_S;
            OPC_BRANCH:         o_imm_src = IMM_B;
            OPC_AUIPC, OPC_LUI: o_imm_src = IMM_U;
            OPC_JAL:            o_imm_src = IMM_J;
            default:            o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32 datapath.
// Optional build macro MC_MEM_HANDSHAKE_EN adds mem_ready_i and lets
// MEM_RD / MEM_WR stall until the data memory reports ready.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       Zero,
`ifdef MC_MEM_HANDSHAKE_EN
    input  logic       mem_ready_i,
`endif
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite_o,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       LatchAB,
    output logic       ALUOutEn,
    output logic [2:0] ImmSrc,
    output logic       illegal_o,
    output logic       retire_o
);

    // XLEN only exists for top-level uniformity; nothing here is data-width dependent
    if (XLEN != 32) begin : g_xlen_unsupported
        $error("multicycle_control supports XLEN=32 only");
    end

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_imm_src;
    logic       w_mem_ready;

`ifdef MC_MEM_HANDSHAKE_EN
    assign w_mem_ready = mem_ready_i;
`else
    assign w_mem_ready = 1'b1;
`endif

    mc_imm_decode u_imm_decode (
        .i_opcode  (opcode),
        .o_imm_src (w_imm_src)
    );

    // Branches resolve inside the FSM, so the conditional PC load is unused
    assign PCWriteCond = 1'b0;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state: linear fetch/decode, opcode dispatch, memory states may stall
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_IRLOAD;
            S_IRLOAD: w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_R:                w_next = S_EXEC_R;
                    OPC_I:                w_next = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:  w_next = S_MEM_ADDR;
                    OPC_BRANCH:           w_next = S_BRANCH;
                    OPC_JAL:              w_next = S_JAL;
                    OPC_JALR:             w_next = S_JALR;
                    OPC_AUIPC:            w_next = S_WB_ALU;
                    default:              w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = w_mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_next = w_mem_ready ? S_FETCH : S_MEM_WR;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    // Output decode: Moore outputs from state, plus branch outcome and memory ready
    always_comb begin
        PCWrite    = 1'b0;
        PCSource   = PCSRC_PC4;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite_o = 1'b0;
        MemtoReg   = WB_ALU;
        RegWrite   = 1'b0;
        ALUOp      = ALUOP_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        LatchAB    = 1'b0;
        ALUOutEn   = 1'b0;
        ImmSrc     = w_imm_src;
        illegal_o  = 1'b0;
        retire_o   = 1'b0;
        case (r_state)
            S_IRLOAD: IRWrite = 1'b1;
            S_DECODE: begin
                // speculative PC+Imm for AUIPC/JAL while rs1/rs2 are latched
                LatchAB  = 1'b1;
                ALUSrcA  = SRCA_PC;
                ALUSrcB  = SRCB_IMM;
                ALUOp    = ALUOP_ADD;
                ALUOutEn = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_B;
                ALUOp    = ALUOP_RFN;
                ALUOutEn = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_IMM;
                ALUOp    = ALUOP_IFN;
                ALUOutEn = 1'b1;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                MemtoReg = WB_ALU;
                PCWrite  = 1'b1;
                PCSource = PCSRC_PC4;
                retire_o = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_IMM;
                ALUOp    = ALUOP_ADD;
                ALUOutEn = 1'b1;
            end
            S_MEM_RD: IorD = 1'b1;
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = WB_MEM;
                PCWrite  = 1'b1;
                PCSource = PCSRC_PC4;
                retire_o = 1'b1;
            end
            S_MEM_WR: begin
                // strobe held through a stall; PC moves only on the accepted cycle
                IorD       = 1'b1;
                MemWrite_o = 1'b1;
                PCWrite    = w_mem_ready;
                PCSource   = PCSRC_PC4;
                retire_o   = w_mem_ready;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_B;
                ALUOp    = ALUOP_SUB;
                PCWrite  = 1'b1;
                PCSource = branch_taken(funct3, Zero) ? PCSRC_ALU : PCSRC_PC4;
                retire_o = 1'b1;
            end
            S_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = WB_PC4;
                PCWrite  = 1'b1;
                PCSource = PCSRC_ALU;
                retire_o = 1'b1;
            end
            S_JALR: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_IMM;
                ALUOp    = ALUOP_ADD;
                RegWrite = 1'b1;
                MemtoReg = WB_PC4;
                PCWrite  = 1'b1;
                PCSource = PCSRC_JALR;
                retire_o = 1'b1;
            end
            S_ILLEGAL: begin
                // parked until reset with every strobe and select quiet
                ImmSrc    = IMM_I;
                illegal_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
